// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//
// Pipeline hazard controller for a 5-stage in-order core. Detects load-use
// hazards (ALU consumer in ID, load in EX) and branch-operand hazards (branch
// compares in ID, so any producer still in EX, or a load in MEM, must drain
// first). A redirect resolved in EX squashes the ID slot and has top priority.
//
// Optional feature: define HAZARD_PERF_EN to build saturating 16-bit stall and
// flush event counters. Without it both counter outputs are constant zero and
// no counter flops exist.
//
// Ports:
//   clk_i            clock
//   rst_n            synchronous active-low reset
//   IFID_RSaddr_i    RS of the instruction in ID
//   IFID_RTaddr_i    RT of the instruction in ID
//   IFID_UsesRT_i    ID instruction reads RT
//   IFID_IsBranch_i  ID instruction is a conditional branch (compares in ID)
//   IDEX_MemRead_i   EX instruction is a load
//   IDEX_RegWrite_i  EX instruction writes a register
//   IDEX_WBaddr_i    destination of the EX instruction
//   EXMEM_MemRead_i  MEM instruction is a load
//   EXMEM_WBaddr_i   destination of the MEM instruction
//   redirect_i       taken branch / jump resolved in EX this cycle
//   PCWrite_o        PC load enable
//   IFIDWrite_o      IF/ID load enable
//   IFIDFlush_o      IF/ID squash
//   IDEXWrite_o      ID/EX load enable (0 = ID/EX loads a control bubble)
//   state_o          current FSM state (RUN=0, STALL=1, FLUSH=2)
//   stall_cnt_o      stall cycles seen (HAZARD_PERF_EN only, else 0)
//   flush_cnt_o      redirect cycles seen (HAZARD_PERF_EN only, else 0)
// -----------------------------------------------------------------------------
module hazard_ctrl (
  input  logic        clk_i,
  input  logic        rst_n,
  input  logic [2:0]  IFID_RSaddr_i,
  input  logic [2:0]  IFID_RTaddr_i,
  input  logic        IFID_UsesRT_i,
  input  logic        IFID_IsBranch_i,
  input  logic        IDEX_MemRead_i,
  input  logic        IDEX_RegWrite_i,
  input  logic [2:0]  IDEX_WBaddr_i,
  input  logic        EXMEM_MemRead_i,
  input  logic [2:0]  EXMEM_WBaddr_i,
  input  logic        redirect_i,
  output logic        PCWrite_o,
  output logic        IFIDWrite_o,
  output logic        IFIDFlush_o,
  output logic        IDEXWrite_o,
  output logic [1:0]  state_o,
  output logic [15:0] stall_cnt_o,
  output logic [15:0] flush_cnt_o
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;
  state_t eff_state;

  logic match_idex;
  logic match_exmem;
  logic load_use;
  logic branch_haz;
  logic hazard;

  // Register 0 is hardwired, so a zero destination never creates a hazard.
  function automatic logic match(input logic [2:0] a, input logic [2:0] rs,
                                 input logic [2:0] rt, input logic uses_rt);
    return (a != 3'd0) && ((a == rs) || (uses_rt && (a == rt)));
  endfunction

  always_comb begin
    match_idex  = match(IDEX_WBaddr_i,  IFID_RSaddr_i, IFID_RTaddr_i, IFID_UsesRT_i);
    match_exmem = match(EXMEM_WBaddr_i, IFID_RSaddr_i, IFID_RTaddr_i, IFID_UsesRT_i);
    load_use    = IDEX_MemRead_i && match_idex;
    branch_haz  = IFID_IsBranch_i &&
                  ((IDEX_RegWrite_i && match_idex) || (EXMEM_MemRead_i && match_exmem));
    hazard      = load_use || branch_haz;
  end

  // While reset is held the outputs behave as if the FSM were in RUN.
  assign eff_state = rst_n ? state_q : RUN;

  always_comb begin
    PCWrite_o   = 1'b1;
    IFIDWrite_o = 1'b1;
    IFIDFlush_o = 1'b0;
    IDEXWrite_o = 1'b1;
    state_d     = RUN;
    if (redirect_i) begin
      IFIDFlush_o = 1'b1;
      IDEXWrite_o = 1'b0;
      state_d     = FLUSH;
    end else begin
      case (eff_state)
        // ID holds a squashed slot, so its operands are meaningless.
        FLUSH: state_d = RUN;
        RUN, STALL: begin
          if (hazard) begin
            PCWrite_o   = 1'b0;
            IFIDWrite_o = 1'b0;
            IDEXWrite_o = 1'b0;
            state_d     = STALL;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n) state_q <= RUN;
    else        state_q <= state_d;
  end

  assign state_o = state_q;

`ifdef HAZARD_PERF_EN
  // PCWrite_o is low only in a hazard stall; IFIDFlush_o is high only on a
  // redirect, so the outputs themselves identify the counted events.
  logic [15:0] stall_cnt_q;
  logic [15:0] flush_cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      stall_cnt_q <= 16'd0;
      flush_cnt_q <= 16'd0;
    end else begin
      if (!PCWrite_o && (stall_cnt_q != 16'hFFFF)) stall_cnt_q <= stall_cnt_q + 16'd1;
      if (IFIDFlush_o && (flush_cnt_q != 16'hFFFF)) flush_cnt_q <= flush_cnt_q + 16'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`else
  assign stall_cnt_o = 16'd0;
  assign flush_cnt_o = 16'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
//
// Directed bench for hazard_ctrl. Inputs are driven 1 time unit after the
// rising edge; combinational outputs are checked 1 unit after driving and
// registered state/counters 1 unit after the edge. Counter expectations come
// from perf_exp(), which yields the saturated event count when the design is
// built with HAZARD_PERF_EN and 0 otherwise.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_n;
  logic [2:0]  IFID_RSaddr_i;
  logic [2:0]  IFID_RTaddr_i;
  logic        IFID_UsesRT_i;
  logic        IFID_IsBranch_i;
  logic        IDEX_MemRead_i;
  logic        IDEX_RegWrite_i;
  logic [2:0]  IDEX_WBaddr_i;
  logic        EXMEM_MemRead_i;
  logic [2:0]  EXMEM_WBaddr_i;
  logic        redirect_i;
  logic        PCWrite_o;
  logic        IFIDWrite_o;
  logic        IFIDFlush_o;
  logic        IDEXWrite_o;
  logic [1:0]  state_o;
  logic [15:0] stall_cnt_o;
  logic [15:0] flush_cnt_o;

  int errors = 0;
  int checks = 0;

  hazard_ctrl dut (
    .clk_i           (clk_i),
    .rst_n           (rst_n),
    .IFID_RSaddr_i   (IFID_RSaddr_i),
    .IFID_RTaddr_i   (IFID_RTaddr_i),
    .IFID_UsesRT_i   (IFID_UsesRT_i),
    .IFID_IsBranch_i (IFID_IsBranch_i),
    .IDEX_MemRead_i  (IDEX_MemRead_i),
    .IDEX_RegWrite_i (IDEX_RegWrite_i),
    .IDEX_WBaddr_i   (IDEX_WBaddr_i),
    .EXMEM_MemRead_i (EXMEM_MemRead_i),
    .EXMEM_WBaddr_i  (EXMEM_WBaddr_i),
    .redirect_i      (redirect_i),
    .PCWrite_o       (PCWrite_o),
    .IFIDWrite_o     (IFIDWrite_o),
    .IFIDFlush_o     (IFIDFlush_o),
    .IDEXWrite_o     (IDEXWrite_o),
    .state_o         (state_o),
    .stall_cnt_o     (stall_cnt_o),
    .flush_cnt_o     (flush_cnt_o)
  );

  // ---------------- clock ----------------
  always #5 clk_i = ~clk_i;

  // ---------------- expected-value helpers ----------------
  function automatic logic [15:0] perf_exp(input int n);
`ifdef HAZARD_PERF_EN
    return (n > 65535) ? 16'hFFFF : n[15:0];
`else
    return (n > 0) ? 16'd0 : 16'd0;
`endif
  endfunction

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // enables packed {PCWrite, IFIDWrite, IFIDFlush, IDEXWrite}
  task automatic check_en(input string tag, input logic [3:0] exp);
    check(tag, {28'd0, PCWrite_o, IFIDWrite_o, IFIDFlush_o, IDEXWrite_o}, {28'd0, exp});
  endtask

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive_idle();
    IFID_RSaddr_i   = 3'd1;
    IFID_RTaddr_i   = 3'd2;
    IFID_UsesRT_i   = 1'b0;
    IFID_IsBranch_i = 1'b0;
    IDEX_MemRead_i  = 1'b0;
    IDEX_RegWrite_i = 1'b0;
    IDEX_WBaddr_i   = 3'd0;
    EXMEM_MemRead_i = 1'b0;
    EXMEM_WBaddr_i  = 3'd0;
    redirect_i      = 1'b0;
  endtask

  task automatic drive_load_use(input logic [2:0] r);
    drive_idle();
    IDEX_MemRead_i  = 1'b1;
    IDEX_RegWrite_i = 1'b1;
    IDEX_WBaddr_i   = r;
    IFID_RSaddr_i   = r;
  endtask

  localparam logic [3:0] EN_RUN   = 4'b1101;
  localparam logic [3:0] EN_STALL = 4'b0000;
  localparam logic [3:0] EN_FLUSH = 4'b1110;

  int long_n;

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    drive_idle();
    tick();
    check("reset_state", state_o, 2'd0);
    check("reset_stall_cnt", stall_cnt_o, 16'd0);
    check("reset_flush_cnt", flush_cnt_o, 16'd0);
    check_en("reset_idle_en", EN_RUN);
    // In reset, outputs still follow RUN equations of the current inputs.
    drive_load_use(3'd3);
    #1 check_en("reset_hazard_en", EN_STALL);
    tick();
    check("reset_holds_run", state_o, 2'd0);
    check("reset_holds_cnt", stall_cnt_o, 16'd0);
    rst_n = 1'b1;
    drive_idle();
    tick();

    // Load-use: one stall cycle, then the load is in MEM and the ALU op goes.
    drive_load_use(3'd3);
    #1 check_en("lu_stall_en", EN_STALL);
    tick();
    check("lu_state_stall", state_o, 2'd1);
    check("lu_stall_cnt", stall_cnt_o, perf_exp(1));
    drive_idle();
    EXMEM_MemRead_i = 1'b1;
    EXMEM_WBaddr_i  = 3'd3;
    IFID_RSaddr_i   = 3'd3;
    #1 check_en("lu_release_en", EN_RUN);
    tick();
    check("lu_state_run", state_o, 2'd0);

    // Load then dependent branch on RT=5: two stall cycles.
    drive_load_use(3'd5);
    IFID_RSaddr_i   = 3'd1;
    IFID_RTaddr_i   = 3'd5;
    IFID_UsesRT_i   = 1'b1;
    IFID_IsBranch_i = 1'b1;
    #1 check_en("br_stall1_en", EN_STALL);
    tick();
    check("br_state1", state_o, 2'd1);
    IDEX_MemRead_i  = 1'b0;
    IDEX_RegWrite_i = 1'b0;
    IDEX_WBaddr_i   = 3'd0;
    EXMEM_MemRead_i = 1'b1;
    EXMEM_WBaddr_i  = 3'd5;
    #1 check_en("br_stall2_en", EN_STALL);
    tick();
    check("br_state2", state_o, 2'd1);
    check("br_stall_cnt", stall_cnt_o, perf_exp(3));
    EXMEM_MemRead_i = 1'b0;
    EXMEM_WBaddr_i  = 3'd0;
    #1 check_en("br_release_en", EN_RUN);
    tick();
    check("br_state_run", state_o, 2'd0);

    // Redirect coincident with a load-use hazard, hazard held afterwards.
    drive_load_use(3'd3);
    redirect_i = 1'b1;
    #1 check_en("rd_flush_en", EN_FLUSH);
    tick();
    check("rd_state_flush", state_o, 2'd2);
    check("rd_flush_cnt", flush_cnt_o, perf_exp(1));
    redirect_i = 1'b0;
    #1 check_en("rd_suppress_en", EN_RUN);
    tick();
    check("rd_state_run", state_o, 2'd0);
    check("rd_stall_cnt", stall_cnt_o, perf_exp(3));

    // Combinational boundary cases, all in RUN.
    drive_load_use(3'd0);
    #1 check_en("addr0_no_stall", EN_RUN);
    drive_load_use(3'd4);
    IFID_RSaddr_i = 3'd1;
    IFID_RTaddr_i = 3'd4;
    #1 check_en("rt_unused_no_stall", EN_RUN);
    IFID_UsesRT_i = 1'b1;
    #1 check_en("rt_used_stall", EN_STALL);
    // ALU producer in EX, non-branch consumer: forwarding covers it.
    drive_idle();
    IDEX_RegWrite_i = 1'b1;
    IDEX_WBaddr_i   = 3'd6;
    IFID_RSaddr_i   = 3'd6;
    #1 check_en("alu_fwd_no_stall", EN_RUN);
    IFID_IsBranch_i = 1'b1;
    #1 check_en("alu_branch_stall", EN_STALL);
    // Non-load in MEM matching a branch: forwarded, no stall.
    drive_idle();
    IFID_IsBranch_i = 1'b1;
    EXMEM_WBaddr_i  = 3'd1;
    #1 check_en("mem_alu_branch_no_stall", EN_RUN);
    drive_idle();
    tick();

    // Reset while in STALL with the hazard held.
    drive_load_use(3'd2);
    tick();
    check("rs_state_stall", state_o, 2'd1);
    check("rs_stall_cnt_pre", stall_cnt_o, perf_exp(4));
    rst_n = 1'b0;
    #1 check_en("rs_reset_en", EN_STALL);
    tick();
    check("rs_state_run", state_o, 2'd0);
    check("rs_stall_cnt_clr", stall_cnt_o, 16'd0);
    rst_n = 1'b1;
    drive_idle();
    tick();

    // Reset while in FLUSH, with redirect asserted in the reset cycle.
    redirect_i = 1'b1;
    tick();
    check("rf_state_flush", state_o, 2'd2);
    check("rf_flush_cnt_pre", flush_cnt_o, perf_exp(1));
    rst_n = 1'b0;
    tick();
    check("rf_state_run", state_o, 2'd0);
    check("rf_flush_cnt_clr", flush_cnt_o, 16'd0);
    rst_n = 1'b1;
    drive_idle();
    tick();

    // Long stall: counter must saturate.
`ifdef HAZARD_PERF_EN
    long_n = 70000;
`else
    long_n = 20;
`endif
    drive_load_use(3'd7);
    repeat (long_n) tick();
    check("long_state_stall", state_o, 2'd1);
    check("long_stall_cnt", stall_cnt_o, perf_exp(long_n));
    check("long_flush_cnt", flush_cnt_o, 16'd0);
    drive_idle();
    tick();
    check("long_release_run", state_o, 2'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have ports: clk_i  in  1  clock; rst_n  in  1  reset, synchronous, active-low.
REQ-002 SHALL have ports: IFID_RSaddr_i  in  3  RS of instruction in ID; IFID_RTaddr_i  in  3  RT of instruction in ID; IFID_UsesRT_i  in  1  ID instruction reads RT.
REQ-003 SHALL have ports: IFID_IsBranch_i  in  1  ID instruction is a conditional branch (compare operands in ID).
REQ-004 SHALL have ports: IDEX_MemRead_i  in  1; IDEX_RegWrite_i  in  1; IDEX_WBaddr_i  in  3  destination of instruction in EX.
REQ-005 SHALL have ports: EXMEM_MemRead_i  in  1; EXMEM_WBaddr_i  in  3  destination of instruction in MEM.
REQ-006 SHALL have ports: redirect_i  in  1  taken branch or jump resolved in EX this cycle.
REQ-007 SHALL have ports: PCWrite_o  out  1; IFIDWrite_o  out  1; IFIDFlush_o  out  1; IDEXWrite_o  out  1  (0 = ID/EX loads a control bubble).
REQ-008 SHALL have ports: state_o  out  2  current FSM state; stall_cnt_o  out  16; flush_cnt_o  out  16.

Function
REQ-009 Register address 0 SHALL never create a hazard.
REQ-010 Match(a) SHALL be (a==IFID_RSaddr_i) or (IFID_UsesRT_i and a==IFID_RTaddr_i), with a!=0.
REQ-011 Load-use hazard SHALL be IDEX_MemRead_i and Match(IDEX_WBaddr_i).
REQ-012 Branch hazard SHALL be IFID_IsBranch_i and ((IDEX_RegWrite_i and Match(IDEX_WBaddr_i)) or (EXMEM_MemRead_i and Match(EXMEM_WBaddr_i))).
REQ-013 FSM states SHALL be RUN=0, STALL=1, FLUSH=2; encoding 3 unreachable and SHALL return to RUN on the next clock.
REQ-014 Outputs SHALL be combinational (Mealy) from state and inputs; only state and counters are registered.
REQ-015 Priority SHALL be: redirect_i > FLUSH-state suppression > hazard > normal.
REQ-016 redirect_i=1 in any state: PCWrite_o=1, IFIDWrite_o=1, IFIDFlush_o=1, IDEXWrite_o=0; next state FLUSH.
REQ-017 In FLUSH with redirect_i=0: hazards SHALL be ignored (ID holds a squashed slot); all write enables 1, IFIDFlush_o=0; next state RUN.
REQ-018 In RUN or STALL with hazard and redirect_i=0: PCWrite_o=0, IFIDWrite_o=0, IFIDFlush_o=0, IDEXWrite_o=0; next state STALL.
REQ-019 In RUN or STALL with no hazard and redirect_i=0: PCWrite_o=1, IFIDWrite_o=1, IFIDFlush_o=0, IDEXWrite_o=1; next state RUN.
REQ-020 Load followed by dependent branch SHALL therefore stall exactly 2 cycles; load followed by dependent ALU op exactly 1 cycle.
REQ-021 state_o SHALL equal the registered state.

Reset
REQ-022 On rising clk_i with rst_n=0: state=RUN, stall_cnt_o=0, flush_cnt_o=0; reset SHALL override redirect_i and any hazard that cycle.
REQ-023 While rst_n=0, outputs SHALL follow RUN-state equations of the current inputs.
REQ-024 Reset asserted mid-STALL or mid-FLUSH SHALL leave state RUN on the following cycle.

Configuration
REQ-025 Macro HAZARD_PERF_EN defined: stall_cnt_o increments by 1 each cycle REQ-018 applies, flush_cnt_o increments by 1 each cycle REQ-016 applies; both saturate at 16'hFFFF.
REQ-026 Macro HAZARD_PERF_EN undefined: stall_cnt_o and flush_cnt_o SHALL be constant 0 and no counter flops SHALL exist; FSM behaviour unchanged.

Verification
REQ-027 Load-use: IDEX_MemRead_i=1, IDEX_WBaddr_i=3, IFID_RSaddr_i=3 -> one cycle PCWrite_o=IFIDWrite_o=IDEXWrite_o=0, state_o=1; then all enables 1, state_o=0; stall_cnt_o=1 (PERF_EN).
REQ-028 Load then branch on RT=5 (IFID_UsesRT_i=1, IsBranch=1) -> 2 stall cycles (IDEX match, then EXMEM_MemRead match), stall_cnt_o=2, then RUN.
REQ-029 redirect_i=1 coincident with load-use hazard -> IFIDFlush_o=1, PCWrite_o=1, IDEXWrite_o=0, state_o=2 next; hazard inputs held next cycle -> no stall, state_o=0; flush_cnt_o=1.
REQ-030 Hazard on address 0 (IDEX_WBaddr_i=0, IFID_RSaddr_i=0, MemRead=1) -> no stall; IFID_UsesRT_i=0 with RT match only -> no stall.
REQ-031 rst_n=0 asserted while in STALL with hazard held -> next state_o=0, counters 0; 70000 consecutive stall cycles with PERF_EN -> stall_cnt_o holds 16'hFFFF.
